// File: rtl/complex_div_pkg.sv
// Shared state encoding, default part width and field helpers for the complex divider.
// Operands pack the real part in the upper half and the imaginary part in the lower half.
package complex_pkg;

   typedef enum logic [1:0] {IDLE, PREP, DIV, FIX} state_t;

   localparam int M_DEF  = 8;
   localparam int PART_W = M_DEF;
   localparam int NUM_W  = 2*M_DEF + 1;
   localparam int DEN_W  = 2*M_DEF;

   function automatic logic signed [PART_W-1:0] cx(input logic [2*PART_W-1:0] v);
      return v[2*PART_W-1:PART_W];
   endfunction

   function automatic logic signed [PART_W-1:0] cy(input logic [2*PART_W-1:0] v);
      return v[PART_W-1:0];
   endfunction

endpackage

// File: rtl/complex_div_udiv.sv
// Restoring unsigned divider: one quotient bit per cycle, W cycles after start_i.
// A zero divisor still runs to completion; the caller discards that result.
module udiv_seq #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start_i,
   input  logic [W-1:0] dividend_i,
   input  logic [W-1:0] divisor_i,
   output logic         ready_o,
   output logic [W-1:0] quot_o,
   output logic [W-1:0] rem_o
);
   localparam int CW = $clog2(W + 1);

   logic [W-1:0]  quot_q, quot_d, rem_q, rem_d, div_q, div_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d, ready_q, ready_d;
   logic [W:0]    shifted, trial;

   always_comb begin
      quot_d  = quot_q;
      rem_d   = rem_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      ready_d = ready_q;
      shifted = {rem_q, quot_q[W-1]};
      // Borrow out of the trial subtraction means the shifted remainder is below the divisor.
      trial   = shifted - {1'b0, div_q};
      if (start_i) begin
         quot_d  = dividend_i;
         rem_d   = '0;
         div_d   = divisor_i;
         cnt_d   = '0;
         busy_d  = 1'b1;
         ready_d = 1'b0;
      end else if (busy_q) begin
         if (!trial[W]) begin
            rem_d  = trial[W-1:0];
            quot_d = {quot_q[W-2:0], 1'b1};
         end else begin
            rem_d  = shifted[W-1:0];
            quot_d = {quot_q[W-2:0], 1'b0};
         end
         cnt_d = cnt_q + CW'(1);
         if (cnt_q == CW'(W-1)) begin
            busy_d  = 1'b0;
            ready_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
      end
   end

   always_ff @(posedge clk) begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      div_q  <= div_d;
   end

   assign ready_o = ready_q;
   assign quot_o  = quot_q;
   assign rem_o   = rem_q;

endmodule

// File: rtl/complex_div.sv
// Sequential complex divider c = a / b with truncation toward zero, divide-by-zero and
// overflow flags; fixed latency of 2M+2 cycles from the accepting edge to ready.
module complex_div
   import complex_pkg::*;
#(
   parameter int M = M_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [2*M-1:0] a,
   input  logic [2*M-1:0] b,
   input  logic           start,
   output logic           ready,
   output logic [2*M-1:0] c,
   output logic           dz,
   output logic           ovf
);
   localparam int W  = 2*M;
   localparam int NW = 2*M + 1;
   localparam int CW = $clog2(W + 1);

   state_t               state_q, state_d;
   logic [W-1:0]         a_q, b_q;
   logic                 sx_q, sy_q, zero_q;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 ready_q, ready_d, dz_q, dz_d, ovf_q, ovf_d;
   logic [W-1:0]         c_q, c_d;
   logic                 latch_ops, div_go, load_res;
   logic signed [NW-1:0] ax, ay, bx, by, num_x, num_y, sq_x, sq_y;
   logic [W-1:0]         mag_x, mag_y, den;
   logic [W-1:0]         q_x, q_y, r_x, r_y;
   logic                 rdy_x, rdy_y;
   logic                 unused_rem;

   function automatic logic signed [NW-1:0] sext(input logic [M-1:0] v);
      return {{(NW-M){v[M-1]}}, v};
   endfunction

   function automatic logic signed [NW-1:0] apply_sign(input logic neg, input logic [W-1:0] mag);
      logic signed [NW-1:0] m;
      m = {1'b0, mag};
      return neg ? -m : m;
   endfunction

   // A value fits M signed bits only when bits NW-1..M-1 all equal the sign bit.
   function automatic logic out_of_range(input logic signed [NW-1:0] v);
      return !((&v[NW-1:M-1]) || !(|v[NW-1:M-1]));
   endfunction

   assign ax    = sext(a_q[W-1:M]);
   assign ay    = sext(a_q[M-1:0]);
   assign bx    = sext(b_q[W-1:M]);
   assign by    = sext(b_q[M-1:0]);
   assign num_x = ax*bx + ay*by;
   assign num_y = ay*bx - ax*by;
   assign den   = W'(bx*bx + by*by);
   assign mag_x = num_x[NW-1] ? W'(-num_x) : W'(num_x);
   assign mag_y = num_y[NW-1] ? W'(-num_y) : W'(num_y);
   assign sq_x  = apply_sign(sx_q, q_x);
   assign sq_y  = apply_sign(sy_q, q_y);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = PREP;
         PREP:    state_d = DIV;
         DIV:     if (cnt_q == CW'(W-1)) state_d = FIX;
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      latch_ops = (state_q == IDLE) && start;
      div_go    = (state_q == PREP);
      load_res  = (state_q == FIX) && rdy_x && rdy_y;
   end

   always_comb begin
      cnt_d   = cnt_q;
      ready_d = ready_q;
      c_d     = c_q;
      dz_d    = dz_q;
      ovf_d   = ovf_q;
      if (latch_ops) ready_d = 1'b0;
      if (div_go)                cnt_d = '0;
      else if (state_q == DIV)   cnt_d = cnt_q + CW'(1);
      if (load_res) begin
         ready_d = 1'b1;
         dz_d    = zero_q;
         c_d     = zero_q ? '0 : {sq_x[M-1:0], sq_y[M-1:0]};
         ovf_d   = !zero_q && (out_of_range(sq_x) || out_of_range(sq_y));
      end
   end

   // Control and result registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q   <= '0;
         ready_q <= 1'b0;
         c_q     <= '0;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
         sx_q    <= 1'b0;
         sy_q    <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         c_q     <= c_d;
         dz_q    <= dz_d;
         ovf_q   <= ovf_d;
         if (div_go) begin
            sx_q   <= num_x[NW-1];
            sy_q   <= num_y[NW-1];
            zero_q <= (den == '0);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (latch_ops) begin
         a_q <= a;
         b_q <= b;
      end
   end

   udiv_seq #(.W(W)) u_div_x (
      .clk       (clk),
      .rst_n     (rst),
      .start_i   (div_go),
      .dividend_i(mag_x),
      .divisor_i (den),
      .ready_o   (rdy_x),
      .quot_o    (q_x),
      .rem_o     (r_x)
   );

   udiv_seq #(.W(W)) u_div_y (
      .clk       (clk),
      .rst_n     (rst),
      .start_i   (div_go),
      .dividend_i(mag_y),
      .divisor_i (den),
      .ready_o   (rdy_y),
      .quot_o    (q_y),
      .rem_o     (r_y)
   );

   assign unused_rem = ^{r_x, r_y};

   assign ready = ready_q;
   assign c     = c_q;
   assign dz    = dz_q;
   assign ovf   = ovf_q;

endmodule
